// File: rtl/cast_switch_alloc.sv
// rtl/cast_switch_alloc.sv - multicast switch allocator with atomic all-or-nothing output grants
`ifndef PN
`define PN 5
`endif

module cast_switch_alloc #(
    parameter int PN = `PN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PN-1:0]         valid_i,
    input  logic [PN-1:0]         head_i,
    input  logic [PN-1:0]         tail_i,
    input  logic [PN-1:0][PN-1:0] req_i,
    input  logic [PN-1:0]         fire_i,
    output logic [PN-1:0][PN-1:0] xbar_sel_o,
    output logic [PN-1:0]         out_busy_o
);

    localparam int PW = (PN > 1) ? $clog2(PN) : 1;

    // Per-input ownership: busy_q marks a packet in flight, mask_q is the output set it holds.
    logic [PN-1:0]         busy_q;
    logic [PN-1:0][PN-1:0] mask_q;
    logic [PW-1:0]         rr_ptr_q;
    logic [PW-1:0]         rr_ptr_d;

    logic [PN-1:0] occ;
    logic [PN-1:0] cand;
    logic [PN-1:0] grant;
    logic [PN-1:0] release_v;
    logic [PN-1:0] claimed;
    logic [PW:0]   visit_sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] first_idx;
    logic          found;

    logic [PN-1:0] seen;
    logic          overlap;

    // Outputs owned by packets already in flight; freed outputs only drop out after the edge.
    always_comb begin
        occ = '0;
        for (int i = 0; i < PN; i++) begin
            if (busy_q[i]) begin
                occ = occ | mask_q[i];
            end
        end
    end

    // Candidate heads and tail releases; req_i only matters for idle inputs with a nonzero mask.
    always_comb begin
        cand      = '0;
        release_v = '0;
        for (int i = 0; i < PN; i++) begin
            cand[i]      = valid_i[i] & head_i[i] & ~busy_q[i] & (|req_i[i]);
            release_v[i] = fire_i[i] & tail_i[i] & busy_q[i];
        end
    end

    // Single round-robin pass: a packet wins only if its whole mask is free of owned and claimed outputs.
    always_comb begin
        grant     = '0;
        claimed   = '0;
        found     = 1'b0;
        first_idx = '0;
        visit_sum = '0;
        idx       = '0;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < PN; k++) begin
            visit_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (visit_sum >= (PW+1)'(PN)) begin
                visit_sum = visit_sum - (PW+1)'(PN);
            end
            idx = visit_sum[PW-1:0];
            if (cand[idx] && ((req_i[idx] & (occ | claimed)) == '0)) begin
                grant[idx] = 1'b1;
                claimed    = claimed | req_i[idx];
                if (!found) begin
                    found     = 1'b1;
                    first_idx = idx;
                end
            end
        end
        if (found) begin
            if (first_idx == PW'(PN - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = first_idx + PW'(1);
            end
        end
    end

    // Grant/release state and pointer; reset drops every grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            mask_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < PN; i++) begin
                if (grant[i]) begin
                    busy_q[i] <= 1'b1;
                    mask_q[i] <= req_i[i];
                end else if (release_v[i]) begin
                    busy_q[i] <= 1'b0;
                    mask_q[i] <= '0;
                end
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Crossbar rows come straight from state, so there is no input-to-output combinational path.
    always_comb begin
        xbar_sel_o = '0;
        for (int i = 0; i < PN; i++) begin
            xbar_sel_o[i] = busy_q[i] ? mask_q[i] : '0;
        end
        out_busy_o = occ;
    end

    // Detect any output claimed by two rows at once.
    always_comb begin
        seen    = '0;
        overlap = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if ((seen & xbar_sel_o[i]) != '0) begin
                overlap = 1'b1;
            end
            seen = seen | xbar_sel_o[i];
        end
    end

    // Crossbar rows must stay pairwise disjoint.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!overlap);
        end
    end

endmodule

// File: tb/tb_cast_switch_alloc.sv
// tb/tb_cast_switch_alloc.sv - scoreboard bench for cast_switch_alloc
`timescale 1ns/1ps

module tb_cast_switch_alloc;

    localparam int PN = 5;

    typedef struct packed {
        logic [4:0]  v;
        logic [4:0]  h;
        logic [4:0]  t;
        logic [4:0]  f;
        logic [24:0] r;
        logic [24:0] es;
        logic [4:0]  eb;
    } cyc_t;

    typedef struct packed {
        logic [24:0] sel;
        logic [4:0]  busy;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [PN-1:0]         valid;
    logic [PN-1:0]         head;
    logic [PN-1:0]         tail;
    logic [PN-1:0][PN-1:0] req;
    logic [PN-1:0]         fire;
    logic [PN-1:0][PN-1:0] xbar_sel;
    logic [PN-1:0]         out_busy;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    cast_switch_alloc #(.PN(PN)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid),
        .head_i     (head),
        .tail_i     (tail),
        .req_i      (req),
        .fire_i     (fire),
        .xbar_sel_o (xbar_sel),
        .out_busy_o (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] row(int i, logic [4:0] m);
        logic [24:0] x;
        x = '0;
        x[i*5 +: 5] = m;
        return x;
    endfunction

    function automatic cyc_t cy(logic [4:0] v, logic [4:0] h, logic [4:0] t, logic [4:0] f,
                                logic [24:0] r, logic [24:0] es, logic [4:0] eb);
        cyc_t c;
        c.v = v; c.h = h; c.t = t; c.f = f; c.r = r; c.es = es; c.eb = eb;
        return c;
    endfunction

    task automatic apply(input cyc_t c);
        valid = c.v;
        head  = c.h;
        tail  = c.t;
        fire  = c.f;
        req   = c.r;
    endtask

    task automatic idle();
        valid = '0;
        head  = '0;
        tail  = '0;
        fire  = '0;
        req   = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        idle();
        sb.push_back('{sel: 25'd0, busy: 5'd0});
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        compared++;
        if (xbar_sel !== e.sel || out_busy !== e.busy) begin
            mismatched++;
            $display("FAIL reset: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                     xbar_sel, out_busy, e.sel, e.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        cyc_t seq[$];
        exp_t e;
        logic [24:0] all_r;
        all_r = '0;
        for (int i = 0; i < PN; i++) all_r = all_r | row(i, 5'b10000);
        for (int g = 0; g < 6; g++) begin
            seq.push_back(cy(5'b11111, 5'b11111, 5'b11111, 5'b00000, all_r,
                             row(g % PN, 5'b10000), 5'b10000));
            seq.push_back(cy(5'b11111, 5'b11111, 5'b11111, 5'(1 << (g % PN)), all_r,
                             25'd0, 5'b00000));
        end
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL round_robin[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_unicast();
        cyc_t seq[$];
        exp_t e;
        seq.push_back(cy(5'b00001, 5'b00001, 5'b00000, 5'b00000, row(0, 5'b00010), row(0, 5'b00010), 5'b00010));
        seq.push_back(cy(5'b00001, 5'b00001, 5'b00000, 5'b00001, row(0, 5'b00010), row(0, 5'b00010), 5'b00010));
        seq.push_back(cy(5'b00001, 5'b00000, 5'b00001, 5'b00001, 25'd0, 25'd0, 5'b00000));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL unicast[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_multicast_atomic();
        cyc_t seq[$];
        exp_t e;
        seq.push_back(cy(5'b00010, 5'b00010, 5'b00000, 5'b00000, row(1, 5'b00100),
                         row(1, 5'b00100), 5'b00100));
        seq.push_back(cy(5'b00110, 5'b00110, 5'b00000, 5'b00010, row(1, 5'b00100) | row(2, 5'b00110),
                         row(1, 5'b00100), 5'b00100));
        seq.push_back(cy(5'b00110, 5'b00100, 5'b00000, 5'b00010, row(2, 5'b00110),
                         row(1, 5'b00100), 5'b00100));
        seq.push_back(cy(5'b00110, 5'b00100, 5'b00010, 5'b00010, row(2, 5'b00110),
                         25'd0, 5'b00000));
        seq.push_back(cy(5'b00100, 5'b00100, 5'b00000, 5'b00000, row(2, 5'b00110),
                         row(2, 5'b00110), 5'b00110));
        seq.push_back(cy(5'b00100, 5'b00100, 5'b00100, 5'b00100, row(2, 5'b00110),
                         25'd0, 5'b00000));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL multicast[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_disjoint_parallel();
        cyc_t seq[$];
        exp_t e;
        seq.push_back(cy(5'b01001, 5'b01001, 5'b00000, 5'b00000, row(0, 5'b00001) | row(3, 5'b01000),
                         row(0, 5'b00001) | row(3, 5'b01000), 5'b01001));
        seq.push_back(cy(5'b01001, 5'b00000, 5'b01001, 5'b01001, 25'd0, 25'd0, 5'b00000));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL parallel[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_single_flit();
        cyc_t seq[$];
        exp_t e;
        seq.push_back(cy(5'b00010, 5'b00010, 5'b00010, 5'b00000, row(1, 5'b00011),
                         row(1, 5'b00011), 5'b00011));
        seq.push_back(cy(5'b00110, 5'b00110, 5'b00010, 5'b00010, row(1, 5'b00011) | row(2, 5'b00001),
                         25'd0, 5'b00000));
        seq.push_back(cy(5'b00100, 5'b00100, 5'b00000, 5'b00000, row(2, 5'b00001),
                         row(2, 5'b00001), 5'b00001));
        seq.push_back(cy(5'b00100, 5'b00000, 5'b00100, 5'b00100, 25'd0, 25'd0, 5'b00000));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL single_flit[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_protocol_corners();
        cyc_t seq[$];
        exp_t e;
        // input 0 offers a zero mask, input 3 a real one
        seq.push_back(cy(5'b01001, 5'b01001, 5'b00000, 5'b00000, row(3, 5'b01000),
                         row(3, 5'b01000), 5'b01000));
        // head on busy input 3 with a new mask, tail fire on idle input 0
        seq.push_back(cy(5'b01000, 5'b01000, 5'b00001, 5'b00001, row(3, 5'b10000),
                         row(3, 5'b01000), 5'b01000));
        seq.push_back(cy(5'b01000, 5'b00000, 5'b01000, 5'b01000, 25'd0, 25'd0, 5'b00000));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL protocol[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_packet();
        cyc_t seq[$];
        exp_t e;
        logic [24:0] all_r;
        all_r = '0;
        for (int i = 0; i < PN; i++) all_r = all_r | row(i, 5'b00001);
        apply(cy(5'b10000, 5'b10000, 5'b00000, 5'b00000, row(4, 5'b11111), 25'd0, 5'd0));
        sb.push_back('{sel: row(4, 5'b11111), busy: 5'b11111});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compared++;
        if (xbar_sel !== e.sel || out_busy !== e.busy) begin
            mismatched++;
            $display("FAIL reset_mid_grant: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                     xbar_sel, out_busy, e.sel, e.busy);
        end
        idle();
        #2;
        rst = 1'b1;
        sb.push_back('{sel: 25'd0, busy: 5'd0});
        #1;
        e = sb.pop_front();
        compared++;
        if (xbar_sel !== e.sel || out_busy !== e.busy) begin
            mismatched++;
            $display("FAIL reset_async: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                     xbar_sel, out_busy, e.sel, e.busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // everyone contends for output 0: a cleared pointer lets input 0 win
        seq.push_back(cy(5'b11111, 5'b11111, 5'b11111, 5'b00000, all_r, row(0, 5'b00001), 5'b00001));
        seq.push_back(cy(5'b11111, 5'b11111, 5'b11111, 5'b00001, all_r, 25'd0, 5'b00000));
        seq.push_back(cy(5'b11110, 5'b11110, 5'b11110, 5'b00000, all_r & ~row(0, 5'b11111),
                         row(1, 5'b00001), 5'b00001));
        foreach (seq[k]) begin
            apply(seq[k]);
            sb.push_back('{sel: seq[k].es, busy: seq[k].eb});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            compared++;
            if (xbar_sel !== e.sel || out_busy !== e.busy) begin
                mismatched++;
                $display("FAIL reset_rr[%0d]: xbar_sel=%h out_busy=%b, expected xbar_sel=%h out_busy=%b",
                         k, xbar_sel, out_busy, e.sel, e.busy);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_unicast();
        test_multicast_atomic();
        test_disjoint_parallel();
        test_single_flit();
        test_protocol_corners();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
